ball: RTL and testbench
=======================

Name: ball

Overview:
- Pong ball engine for the DE2 VGA lab.
- Consumes the vertical positions produced by the left and right paddle blocks.
- Advances the ball by one pixel per axis per BallClock tick, bounces it off the top/bottom bars and the paddles, detects misses, and keeps the score.
- Outputs the ball's top-left corner for the pixel renderer, plus score and game-over status.

Parameters:
- xScreen, 1280, horizontal resolution; right miss boundary.
- yTopBar, 100, lowest y the ball top may reach.
- yBottomBar, 924, highest y the ball bottom may reach.
- BallSize, 16, ball edge length in pixels.
- PaddleHeight, 200, paddle height (must match the paddle blocks).
- PaddleWidth, 16, paddle width.
- xLeftPaddle, 64, x of the left paddle's left edge.
- xRightPaddle, 1200, x of the right paddle's left edge.
- ServeDelay, 64, ticks spent in S_Serve before the ball moves.
- WinScore, 9, score that ends the game.

Ports:
- BallClock  input  1  movement clock, same tick as PaddleClock.
- SW  input  1  synchronous active-high reset.
- yPaddleLeft  input  11  left paddle top y.
- yPaddleRight  input  11  right paddle top y.
- x  output reg  11  ball left edge.
- y  output reg  11  ball top edge.
- ScoreLeft  output reg  4  left player points.
- ScoreRight  output reg  4  right player points.
- GameOver  output reg  1  high while in S_GameOver.

Behaviour:
- One clock, BallClock. SW is synchronous, active-high and overrides all other logic on any edge, mid-rally included.
- Reset values:
  - x = (xScreen-BallSize)/2 = 632; y = (yTopBar+yBottomBar-BallSize)/2 = 504.
  - ScoreLeft = ScoreRight = 0; GameOver = 0.
  - dx = right, dy = down; serve counter = 0; state = S_Serve.
- States:
  - S_Serve: ball held at centre. Counter increments each tick; at count ServeDelay-1, go to S_Move with the counter cleared.
  - S_Move, every tick, in this order:
    - (a) Vertical: if dy=up and y <= yTopBar, dy becomes down. If dy=down and y+BallSize >= yBottomBar, dy becomes up.
    - (b) Left paddle hit: dx=left, x == xLeftPaddle+PaddleWidth, y+BallSize > yPaddleLeft and y < yPaddleLeft+PaddleHeight. Then dx becomes right.
    - (c) Right paddle hit: dx=right, x+BallSize == xRightPaddle, with the same overlap test against yPaddleRight. Then dx becomes left.
    - (d) Position update: x and y each move ±1 using the updated dx/dy, so the ball never overlaps a bar or paddle.
    - (e) Miss, evaluated before (d) and suppressing it:
      - dx=left and x == 0: ScoreRight increments, serve direction becomes left, go to S_Score.
      - dx=right and x+BallSize == xScreen: ScoreLeft increments, serve direction becomes right, go to S_Score.
  - S_Score (one tick):
    - Ball returns to the centre position; dy = down; dx = serve direction, i.e. toward the player who lost the point.
    - If either score equals WinScore, go to S_GameOver; otherwise go to S_Serve.
  - S_GameOver: ball held at centre; GameOver = 1. Only SW exits this state.
- Simultaneous events:
  - A corner hit (bar and paddle in the same tick) flips both dx and dy in that tick.
  - Paddle overlap is tested against the paddle inputs sampled on the same edge.
- Arithmetic and widths:
  - All compares are 11-bit unsigned. Sums such as y+BallSize are computed 12 bits wide, so no wrap occurs.
  - Scores never exceed WinScore.

Decomposition:
- Shared package holds:
  - State encodings S_Serve, S_Move, S_Score, S_GameOver.
  - Screen and bar constants: xScreen, yTopBar, yBottomBar.
  - PaddleHeight, shared with the paddle blocks.
- One natural sub-module, paddle_hit: combinational overlap test taking ball y, paddle y and BallSize/PaddleHeight, instantiated once per side.

Test Plan:
- Reset and serve: assert SW for 1 tick, then hold paddles at 412.
  - x=632, y=504, scores 0, GameOver=0.
  - Position is unchanged for 64 ticks, then x=633, y=505 on the next tick.
- Bottom bounce: free run with no paddle contact.
  - After 404 moving ticks, y=908 and dy flips.
  - On the following tick y=907 and x keeps increasing.
- Right paddle hit: yPaddleRight=700, with the ball arriving at x=1184, y=760.
  - dx flips; next x=1183, next y=759.
  - ScoreLeft stays 0.
- Right miss: yPaddleRight=100.
  - Ball passes to x=1264.
  - Then ScoreLeft=1, ball returns to (632,504), dx=right, and S_Serve waits 64 ticks.
- Game over: force nine left-scoring misses.
  - ScoreLeft=9, GameOver=1, ball fixed at (632,504) regardless of paddles.
  - SW then clears all scores and GameOver.
- Reset mid-rally: assert SW while x=900.
  - Next edge gives x=632, y=504, state S_Serve, scores 0.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared Pong constants and encodings for the ball, paddles and renderer.
package ball_pkg;

  localparam int unsigned xScreen      = 1280;
  localparam int unsigned yTopBar      = 100;
  localparam int unsigned yBottomBar   = 924;
  localparam int unsigned PaddleHeight = 200;

  typedef enum logic [1:0] {
    S_Serve,
    S_Move,
    S_Score,
    S_GameOver
  } state_t;

  // Inc means right for dx and down for dy.
  typedef enum logic {
    DirDec = 1'b0,
    DirInc = 1'b1
  } dir_t;

endpackage

// File: rtl/ball_paddle_hit.sv
// Vertical overlap test between the ball and one paddle, 12-bit wide sums.
module paddle_hit #(
  parameter int unsigned BallSize     = 16,
  parameter int unsigned PaddleHeight = 200
) (
  input  logic [10:0] yBall,
  input  logic [10:0] yPaddle,
  output logic        overlap
);

  logic [11:0] ballBottom;
  logic [11:0] paddleBottom;

  always_comb begin
    ballBottom   = {1'b0, yBall} + 12'(BallSize);
    paddleBottom = {1'b0, yPaddle} + 12'(PaddleHeight);
    overlap      = (ballBottom > {1'b0, yPaddle}) && ({1'b0, yBall} < paddleBottom);
  end

endmodule

// File: rtl/ball.sv
// Pong ball engine: serve, movement, bar/paddle bounces, misses and scoring.
module ball
  import ball_pkg::*;
#(
  parameter int unsigned BallSize    = 16,
  parameter int unsigned PaddleWidth = 16,
  parameter int unsigned xLeftPaddle = 64,
  parameter int unsigned xRightPaddle = 1200,
  parameter int unsigned ServeDelay  = 64,
  parameter int unsigned WinScore    = 9
) (
  input  logic        BallClock,
  input  logic        SW,
  input  logic [10:0] yPaddleLeft,
  input  logic [10:0] yPaddleRight,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [3:0]  ScoreLeft,
  output logic [3:0]  ScoreRight,
  output logic        GameOver
);

  localparam int unsigned CntW = $clog2(ServeDelay + 1);
  localparam logic [10:0] xCentre = 11'((xScreen - BallSize) / 2);
  localparam logic [10:0] yCentre = 11'((yTopBar + yBottomBar - BallSize) / 2);

  state_t           state;
  dir_t             dx;
  dir_t             dy;
  dir_t             serveDir;
  logic [CntW-1:0]  serveCnt;

  logic        overlapLeft;
  logic        overlapRight;
  logic [11:0] xRightEdge;
  logic [11:0] yBottomEdge;
  dir_t        dxNext;
  dir_t        dyNext;
  logic        missLeft;
  logic        missRight;

  paddle_hit #(.BallSize(BallSize), .PaddleHeight(PaddleHeight)) uHitLeft (
    .yBall   (y),
    .yPaddle (yPaddleLeft),
    .overlap (overlapLeft)
  );

  paddle_hit #(.BallSize(BallSize), .PaddleHeight(PaddleHeight)) uHitRight (
    .yBall   (y),
    .yPaddle (yPaddleRight),
    .overlap (overlapRight)
  );

  // Directions are resolved before the step so the ball never enters a bar or paddle.
  always_comb begin
    xRightEdge  = {1'b0, x} + 12'(BallSize);
    yBottomEdge = {1'b0, y} + 12'(BallSize);
    dyNext = dy;
    if (dy == DirDec && {1'b0, y} <= 12'(yTopBar)) dyNext = DirInc;
    if (dy == DirInc && yBottomEdge >= 12'(yBottomBar)) dyNext = DirDec;
    dxNext = dx;
    if (dx == DirDec && {1'b0, x} == 12'(xLeftPaddle + PaddleWidth) && overlapLeft)
      dxNext = DirInc;
    if (dx == DirInc && xRightEdge == 12'(xRightPaddle) && overlapRight)
      dxNext = DirDec;
    missLeft  = (dx == DirDec) && (x == '0);
    missRight = (dx == DirInc) && (xRightEdge == 12'(xScreen));
  end

  always_ff @(posedge BallClock) begin
    if (SW) begin
      state      <= S_Serve;
      x          <= xCentre;
      y          <= yCentre;
      dx         <= DirInc;
      dy         <= DirInc;
      serveDir   <= DirInc;
      serveCnt   <= '0;
      ScoreLeft  <= '0;
      ScoreRight <= '0;
      GameOver   <= 1'b0;
    end else begin
      unique case (state)
        S_Serve: begin
          x <= xCentre;
          y <= yCentre;
          if (serveCnt == CntW'(ServeDelay - 1)) begin
            serveCnt <= '0;
            state    <= S_Move;
          end else begin
            serveCnt <= serveCnt + 1'b1;
          end
        end
        S_Move: begin
          if (missLeft) begin
            ScoreRight <= ScoreRight + 4'd1;
            serveDir   <= DirDec;
            state      <= S_Score;
          end else if (missRight) begin
            ScoreLeft <= ScoreLeft + 4'd1;
            serveDir  <= DirInc;
            state     <= S_Score;
          end else begin
            dx <= dxNext;
            dy <= dyNext;
            x  <= (dxNext == DirInc) ? x + 11'd1 : x - 11'd1;
            y  <= (dyNext == DirInc) ? y + 11'd1 : y - 11'd1;
          end
        end
        S_Score: begin
          x        <= xCentre;
          y        <= yCentre;
          dy       <= DirInc;
          dx       <= serveDir;
          serveCnt <= '0;
          if (ScoreLeft == 4'(WinScore) || ScoreRight == 4'(WinScore)) begin
            state    <= S_GameOver;
            GameOver <= 1'b1;
          end else begin
            state <= S_Serve;
          end
        end
        S_GameOver: begin
          x        <= xCentre;
          y        <= yCentre;
          GameOver <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball.sv
// Directed bench for the Pong ball engine.
module tb_ball;

  logic        BallClock;
  logic        SW;
  logic [10:0] yPaddleLeft;
  logic [10:0] yPaddleRight;
  logic [10:0] x;
  logic [10:0] y;
  logic [3:0]  ScoreLeft;
  logic [3:0]  ScoreRight;
  logic        GameOver;

  int unsigned checks;
  int unsigned failures;

  ball dut (
    .BallClock    (BallClock),
    .SW           (SW),
    .yPaddleLeft  (yPaddleLeft),
    .yPaddleRight (yPaddleRight),
    .x            (x),
    .y            (y),
    .ScoreLeft    (ScoreLeft),
    .ScoreRight   (ScoreRight),
    .GameOver     (GameOver)
  );

  initial begin
    BallClock = 1'b0;
    forever #5 BallClock = ~BallClock;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge BallClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkPos(input string tag, input int unsigned ex, input int unsigned ey);
    check({tag, ".x"}, 32'(x), 32'(ex));
    check({tag, ".y"}, 32'(y), 32'(ey));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    SW           = 1'b1;
    yPaddleLeft  = 11'd412;
    yPaddleRight = 11'd412;

    // Reset and serve
    tick(1);
    SW = 1'b0;
    checkPos("reset", 632, 504);
    check("reset.ScoreLeft", 32'(ScoreLeft), 0);
    check("reset.ScoreRight", 32'(ScoreRight), 0);
    check("reset.GameOver", 32'(GameOver), 0);
    tick(63);
    checkPos("serve63", 632, 504);
    tick(1);
    checkPos("serve64", 632, 504);
    tick(1);
    checkPos("firstMove", 633, 505);

    // Bottom bounce, then right paddle at 700
    yPaddleRight = 11'd700;
    tick(403);
    checkPos("bottomBar", 1036, 908);
    tick(1);
    checkPos("bottomBounce", 1037, 907);
    tick(147);
    checkPos("rightArrive", 1184, 760);
    tick(1);
    checkPos("rightBounce", 1183, 759);
    check("rightBounce.ScoreLeft", 32'(ScoreLeft), 0);

    // Top bar bounce and left paddle hit at 412
    tick(659);
    checkPos("topBar", 524, 100);
    tick(1);
    checkPos("topBounce", 523, 101);
    tick(443);
    checkPos("leftArrive", 80, 544);
    tick(1);
    checkPos("leftBounce", 81, 545);
    check("leftBounce.ScoreRight", 32'(ScoreRight), 0);

    // Right miss with paddle at 100
    SW = 1'b1;
    yPaddleRight = 11'd100;
    tick(1);
    SW = 1'b0;
    tick(696);
    checkPos("missEdge", 1264, 680);
    check("missEdge.ScoreLeft", 32'(ScoreLeft), 0);
    tick(1);
    checkPos("missTick", 1264, 680);
    check("missTick.ScoreLeft", 32'(ScoreLeft), 1);
    check("missTick.GameOver", 32'(GameOver), 0);
    tick(1);
    checkPos("scoreCentre", 632, 504);
    tick(64);
    checkPos("reserve", 632, 504);
    tick(1);
    checkPos("reserveMove", 633, 505);

    // Game over after nine left points
    tick(631);
    checkPos("rally2Edge", 1264, 680);
    tick(1);
    check("point2.ScoreLeft", 32'(ScoreLeft), 2);
    tick(1);
    check("point2.GameOver", 32'(GameOver), 0);
    for (int k = 3; k <= 9; k++) begin
      tick(64 + 632 + 1);
      check("pointN.ScoreLeft", 32'(ScoreLeft), 32'(k));
      tick(1);
      check("pointN.GameOver", 32'(GameOver), (k == 9) ? 32'd1 : 32'd0);
    end
    checkPos("gameOverCentre", 632, 504);
    yPaddleLeft  = 11'd0;
    yPaddleRight = 11'd800;
    tick(50);
    checkPos("gameOverHeld", 632, 504);
    check("gameOverHeld.GameOver", 32'(GameOver), 1);
    check("gameOverHeld.ScoreLeft", 32'(ScoreLeft), 9);
    check("gameOverHeld.ScoreRight", 32'(ScoreRight), 0);
    SW = 1'b1;
    tick(1);
    check("clear.ScoreLeft", 32'(ScoreLeft), 0);
    check("clear.GameOver", 32'(GameOver), 0);
    checkPos("clear", 632, 504);

    // Reset mid-rally
    SW = 1'b0;
    yPaddleLeft  = 11'd412;
    yPaddleRight = 11'd412;
    tick(332);
    checkPos("midRally", 900, 772);
    SW = 1'b1;
    tick(1);
    SW = 1'b0;
    checkPos("midReset", 632, 504);
    check("midReset.ScoreLeft", 32'(ScoreLeft), 0);
    check("midReset.ScoreRight", 32'(ScoreRight), 0);
    tick(64);
    checkPos("midServe", 632, 504);
    tick(1);
    checkPos("midServeMove", 633, 505);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
